mac_array_tile: RTL and testbench



---
 rtl/mac_array_tile.sv | 149 ++++++++++++++
 tb/tb_mac_array_tile.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_tile.sv
// mac_array_tile: NUM_MACS signed multiply-accumulate lanes with per-lane mode
// (off / multiply / running accumulate / windowed accumulate). Configuration is
// loaded through a serial shift chain and latched into the active config by
// cset, so several tiles can be daisy-chained via shift_out / cset_out.
module mac_array_tile #(
    parameter int NUM_MACS = 4,
    parameter int IN_W     = 8,
    parameter int ACC_W    = 32,
    parameter int CNT_W    = 8,
    parameter int CONF_W   = 2*NUM_MACS + CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      cen,
    input  logic                      cset,
    input  logic                      shift_in,
    output logic                      shift_out,
    output logic                      cset_out,
    input  logic [NUM_MACS*IN_W-1:0]  a,
    input  logic [NUM_MACS*IN_W-1:0]  b,
    output logic [NUM_MACS*ACC_W-1:0] out,
    output logic [NUM_MACS-1:0]       out_valid
);

    typedef enum logic [1:0] {
        MODE_OFF = 2'b00,
        MODE_MUL = 2'b01,
        MODE_ACC = 2'b10,
        MODE_WIN = 2'b11
    } mode_t;

    logic [CONF_W-1:0] chain;
    logic [CONF_W-1:0] active_cfg;
    logic [CNT_W-1:0]  beat;
    logic [CNT_W-1:0]  acc_len;
    logic [CNT_W-1:0]  last_idx;
    logic              last_beat;

    assign shift_out = chain[CONF_W-1];

    // Config chain shifts on cen; cset captures the chain value seen before any
    // shift happening in the same cycle, and is forwarded to the next tile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain      <= '0;
            active_cfg <= '0;
            cset_out   <= 1'b0;
        end else begin
            if (cen) begin
                chain <= {chain[CONF_W-2:0], shift_in};
            end
            if (cset) begin
                active_cfg <= chain;
            end
            cset_out <= cset;
        end
    end

    // Window length decode: a programmed length of 0 behaves as length 1.
    always_comb begin
        acc_len   = active_cfg[CNT_W-1:0];
        last_idx  = (acc_len == '0) ? '0 : acc_len - 1'b1;
        last_beat = (beat == last_idx);
    end

    // Shared beat counter; a beat coinciding with cset or clr is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat <= '0;
        end else if (cset || clr) begin
            beat <= '0;
        end else if (en) begin
            beat <= last_beat ? '0 : beat + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_MACS; g++) begin : g_lane
        logic signed [IN_W-1:0]   op_a;
        logic signed [IN_W-1:0]   op_b;
        logic signed [2*IN_W-1:0] prod_full;
        logic [ACC_W-1:0]         prod;
        logic [ACC_W-1:0]         sum;
        logic [ACC_W-1:0]         acc;
        logic [ACC_W-1:0]         lane_out;
        logic                     lane_vld;
        mode_t                    lane_mode;

        // Signed lane product, sign-extended to accumulator width; sums wrap.
        always_comb begin
            op_a      = a[g*IN_W +: IN_W];
            op_b      = b[g*IN_W +: IN_W];
            prod_full = op_a * op_b;
            prod      = ACC_W'(prod_full);
            sum       = acc + prod;
            lane_mode = mode_t'(active_cfg[CNT_W + 2*g +: 2]);
        end

        // Lane datapath: cset and clr both clear state and take priority over en.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc      <= '0;
                lane_out <= '0;
                lane_vld <= 1'b0;
            end else if (cset || clr) begin
                acc      <= '0;
                lane_out <= '0;
                lane_vld <= 1'b0;
            end else if (en) begin
                case (lane_mode)
                    MODE_OFF: begin
                        acc      <= '0;
                        lane_out <= '0;
                        lane_vld <= 1'b0;
                    end
                    MODE_MUL: begin
                        lane_out <= prod;
                        lane_vld <= 1'b1;
                    end
                    MODE_ACC: begin
                        acc      <= sum;
                        lane_out <= sum;
                        lane_vld <= 1'b1;
                    end
                    MODE_WIN: begin
                        if (last_beat) begin
                            acc      <= '0;
                            lane_out <= sum;
                            lane_vld <= 1'b1;
                        end else begin
                            acc      <= sum;
                            lane_vld <= 1'b0;
                        end
                    end
                    default: begin
                        lane_vld <= 1'b0;
                    end
                endcase
            end else begin
                lane_vld <= 1'b0;
            end
        end

        assign out[g*ACC_W +: ACC_W] = lane_out;
        assign out_valid[g]          = lane_vld;
    end

endmodule

// File: tb/tb_mac_array_tile.sv
// Self-checking bench for mac_array_tile. Expected results are pushed to a
// scoreboard queue as stimulus is planned and popped after each clock edge.
module tb_mac_array_tile;

    localparam int NM  = 4;
    localparam int IW  = 8;
    localparam int AW  = 20;
    localparam int CW  = 8;
    localparam int CFW = 2*NM + CW;

    logic clk = 1'b0;
    logic rst, en, clr, cen, cset, shift_in, shift_out, cset_out;
    logic [NM*IW-1:0] a, b;
    logic [NM*AW-1:0] out;
    logic [NM-1:0]    out_valid;

    typedef struct {
        logic [NM-1:0]    vld;
        logic [NM*AW-1:0] o;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_array_tile #(.NUM_MACS(NM), .IN_W(IW), .ACC_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .cen(cen), .cset(cset),
        .shift_in(shift_in), .shift_out(shift_out), .cset_out(cset_out),
        .a(a), .b(b), .out(out), .out_valid(out_valid)
    );

    function automatic logic [NM*AW-1:0] pk(input int o0, input int o1, input int o2, input int o3);
        logic [NM*AW-1:0] v;
        v[0*AW +: AW] = AW'(o0);
        v[1*AW +: AW] = AW'(o1);
        v[2*AW +: AW] = AW'(o2);
        v[3*AW +: AW] = AW'(o3);
        return v;
    endfunction

    function automatic logic [NM*IW-1:0] opk(input int x0, input int x1, input int x2, input int x3);
        logic [NM*IW-1:0] v;
        v[0*IW +: IW] = IW'(x0);
        v[1*IW +: IW] = IW'(x1);
        v[2*IW +: IW] = IW'(x2);
        v[3*IW +: IW] = IW'(x3);
        return v;
    endfunction

    function automatic exp_t mk(input logic [NM-1:0] v, input logic [NM*AW-1:0] o);
        exp_t t;
        t.vld = v;
        t.o   = o;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic d_en, input logic d_clr);
        en  = d_en;
        clr = d_clr;
        tick();
        en  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic shift_word(input logic [CFW-1:0] v);
        cen = 1'b1;
        for (int i = CFW-1; i >= 0; i--) begin
            shift_in = v[i];
            tick();
        end
        cen      = 1'b0;
        shift_in = 1'b0;
    endtask

    task automatic load_cfg(input logic [CFW-1:0] v);
        shift_word(v);
        cset = 1'b1;
        tick();
        cset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        #3;
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", out); end
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_vld got %b exp 0", out_valid); end
        checks++; if (shift_out !== 1'b0) begin errors++; $display("FAIL reset_so got %b exp 0", shift_out); end
        checks++; if (cset_out !== 1'b0) begin errors++; $display("FAIL reset_co got %b exp 0", cset_out); end
        tick();
        rst = 1'b1;
        tick();
        // async reset of config path while cset_out and shift_out are high
        load_cfg(16'h8001);
        checks++; if (cset_out !== 1'b1) begin errors++; $display("FAIL pre_rst_co got %b exp 1", cset_out); end
        checks++; if (shift_out !== 1'b1) begin errors++; $display("FAIL pre_rst_so got %b exp 1", shift_out); end
        #2 rst = 1'b0;
        #1;
        checks++; if (cset_out !== 1'b0) begin errors++; $display("FAIL async_rst_co got %b exp 0", cset_out); end
        checks++; if (shift_out !== 1'b0) begin errors++; $display("FAIL async_rst_so got %b exp 0", shift_out); end
        #1 rst = 1'b1;
        tick();
        // async reset of datapath while a result is valid
        load_cfg(16'h8001);
        a = opk(0, 0, 0, 7);
        b = opk(0, 0, 0, -2);
        sb.push_back(mk(4'b1000, pk(0, 0, 0, -14)));
        drive(1'b1, 1'b0);
        e = sb.pop_front();
        checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL pre_rst_vld got %b exp %b", out_valid, e.vld); end
        checks++; if (out !== e.o) begin errors++; $display("FAIL pre_rst_out got %h exp %h", out, e.o); end
        #2 rst = 1'b0;
        #1;
        checks++; if (out !== '0) begin errors++; $display("FAIL async_rst_out got %h exp 0", out); end
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL async_rst_vld got %b exp 0", out_valid); end
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_shift();
        logic [15:0] old_w;
        logic [15:0] pat;
        logic        exp_bit;
        old_w = 16'h00C3;
        pat   = 16'hA53C;
        shift_word(old_w);
        cset = 1'b1;
        tick();
        cset = 1'b0;
        checks++; if (cset_out !== 1'b1) begin errors++; $display("FAIL cset_out_pulse got %b exp 1", cset_out); end
        checks++; if (dut.active_cfg !== old_w) begin errors++; $display("FAIL active_c3 got %h exp %h", dut.active_cfg, old_w); end
        a = opk(9, -9, 100, -1);
        b = opk(9, 9, 2, -1);
        drive(1'b1, 1'b0);
        checks++; if (cset_out !== 1'b0) begin errors++; $display("FAIL cset_out_end got %b exp 0", cset_out); end
        checks++; if (out !== '0) begin errors++; $display("FAIL off_out got %h exp 0", out); end
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL off_vld got %b exp 0", out_valid); end
        cen = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp_bit = (k < 16) ? old_w[15-k] : pat[31-k];
            checks++; if (shift_out !== exp_bit) begin errors++; $display("FAIL shift_out k=%0d got %b exp %b", k, shift_out, exp_bit); end
            shift_in = (k < 16) ? pat[15-k] : 1'b0;
            tick();
        end
        cen      = 1'b0;
        shift_in = 1'b0;
    endtask

    task automatic test_mul_acc();
        logic en_pat [5];
        exp_t e;
        en_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        load_cfg(16'h0900);
        a = opk(-3, -3, 0, 0);
        b = opk(5, 5, 0, 0);
        sb.push_back(mk(4'b0011, pk(-15, -15, 0, 0)));
        sb.push_back(mk(4'b0000, pk(-15, -15, 0, 0)));
        sb.push_back(mk(4'b0011, pk(-15, -30, 0, 0)));
        sb.push_back(mk(4'b0011, pk(-15, -45, 0, 0)));
        sb.push_back(mk(4'b0000, pk(-15, -45, 0, 0)));
        for (int k = 0; k < 5; k++) begin
            drive(en_pat[k], 1'b0);
            e = sb.pop_front();
            checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL mulacc_vld k=%0d got %b exp %b", k, out_valid, e.vld); end
            checks++; if (out !== e.o) begin errors++; $display("FAIL mulacc_out k=%0d got %h exp %h", k, out, e.o); end
        end
    endtask

    task automatic test_window();
        exp_t e;
        load_cfg(16'h3004);
        a = opk(0, 0, 2, 0);
        b = opk(0, 0, 3, 0);
        for (int k = 1; k <= 9; k++)
            sb.push_back(mk((k == 4 || k == 8) ? 4'b0100 : 4'b0000, pk(0, 0, (k < 4) ? 0 : 24, 0)));
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL win_vld beat=%0d got %b exp %b", k, out_valid, e.vld); end
            checks++; if (out !== e.o) begin errors++; $display("FAIL win_out beat=%0d got %h exp %h", k, out, e.o); end
        end
        // beat 9 opened a new window; clr restarts the counter and partial sum
        sb.push_back(mk(4'b0000, pk(0, 0, 0, 0)));
        for (int k = 1; k <= 4; k++)
            sb.push_back(mk((k == 4) ? 4'b0100 : 4'b0000, pk(0, 0, (k == 4) ? 24 : 0, 0)));
        drive(1'b0, 1'b1);
        e = sb.pop_front();
        checks++; if (out !== e.o) begin errors++; $display("FAIL win_clr_out got %h exp %h", out, e.o); end
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL win_clr_vld beat=%0d got %b exp %b", k, out_valid, e.vld); end
            checks++; if (out !== e.o) begin errors++; $display("FAIL win_clr_out beat=%0d got %h exp %h", k, out, e.o); end
        end
        // reload mid-window discards the partial window
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        load_cfg(16'h3004);
        for (int k = 1; k <= 4; k++)
            sb.push_back(mk((k == 4) ? 4'b0100 : 4'b0000, pk(0, 0, (k == 4) ? 24 : 0, 0)));
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL win_reload_vld beat=%0d got %b exp %b", k, out_valid, e.vld); end
            checks++; if (out !== e.o) begin errors++; $display("FAIL win_reload_out beat=%0d got %h exp %h", k, out, e.o); end
        end
    endtask

    task automatic test_len0();
        exp_t e;
        load_cfg(16'hFF00);
        for (int k = 0; k < 4; k++)
            sb.push_back(mk(4'b1111, (k % 2 == 0) ? pk(3, -8, -16256, 16384) : pk(-5, 12, -21, 32)));
        for (int k = 0; k < 4; k++) begin
            a = (k % 2 == 0) ? opk(1, -2, 127, -128) : opk(5, 6, 7, 8);
            b = (k % 2 == 0) ? opk(3, 4, -128, -128) : opk(-1, 2, -3, 4);
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL len0_vld k=%0d got %b exp %b", k, out_valid, e.vld); end
            checks++; if (out !== e.o) begin errors++; $display("FAIL len0_out k=%0d got %h exp %h", k, out, e.o); end
        end
    endtask

    task automatic test_acc_wrap();
        exp_t e;
        load_cfg(16'h0200);
        a = opk(-128, 0, 0, 0);
        b = opk(-128, 0, 0, 0);
        // 64 * 16384 = 2^20 wraps a 20-bit accumulator back to zero
        for (int k = 1; k <= 70; k++)
            sb.push_back(mk(4'b0001, pk(k * 16384, 0, 0, 0)));
        for (int k = 1; k <= 70; k++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL wrap_vld beat=%0d got %b exp %b", k, out_valid, e.vld); end
            checks++; if (out !== e.o) begin errors++; $display("FAIL wrap_out beat=%0d got %h exp %h", k, out, e.o); end
        end
        sb.push_back(mk(4'b0000, pk(0, 0, 0, 0)));
        sb.push_back(mk(4'b0001, pk(16384, 0, 0, 0)));
        drive(1'b1, 1'b1);
        e = sb.pop_front();
        checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL wrap_clr_vld got %b exp %b", out_valid, e.vld); end
        checks++; if (out !== e.o) begin errors++; $display("FAIL wrap_clr_out got %h exp %h", out, e.o); end
        drive(1'b1, 1'b0);
        e = sb.pop_front();
        checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL wrap_after_vld got %b exp %b", out_valid, e.vld); end
        checks++; if (out !== e.o) begin errors++; $display("FAIL wrap_after_out got %h exp %h", out, e.o); end
    endtask

    task automatic test_cset_collide();
        exp_t e;
        shift_word(16'h0900);
        cen = 1'b1; shift_in = 1'b1; cset = 1'b1;
        tick();
        cen = 1'b0; shift_in = 1'b0; cset = 1'b0;
        checks++; if (dut.active_cfg !== 16'h0900) begin errors++; $display("FAIL cset_cen_active got %h exp 0900", dut.active_cfg); end
        a = opk(-3, -3, 0, 0);
        b = opk(5, 5, 0, 0);
        sb.push_back(mk(4'b0011, pk(-15, -15, 0, 0)));
        sb.push_back(mk(4'b0011, pk(-15, -30, 0, 0)));
        sb.push_back(mk(4'b0000, pk(0, 0, 0, 0)));
        sb.push_back(mk(4'b0011, pk(-15, -15, 0, 0)));
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL cset_cen_vld k=%0d got %b exp %b", k, out_valid, e.vld); end
            checks++; if (out !== e.o) begin errors++; $display("FAIL cset_cen_out k=%0d got %h exp %h", k, out, e.o); end
        end
        shift_word(16'h0900);
        cset = 1'b1; en = 1'b1;
        tick();
        cset = 1'b0; en = 1'b0;
        e = sb.pop_front();
        checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL cset_en_vld got %b exp %b", out_valid, e.vld); end
        checks++; if (out !== e.o) begin errors++; $display("FAIL cset_en_out got %h exp %h", out, e.o); end
        drive(1'b1, 1'b0);
        e = sb.pop_front();
        checks++; if (out_valid !== e.vld) begin errors++; $display("FAIL cset_en_next_vld got %b exp %b", out_valid, e.vld); end
        checks++; if (out !== e.o) begin errors++; $display("FAIL cset_en_next_out got %h exp %h", out, e.o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        en = 1'b0; clr = 1'b0; cen = 1'b0; cset = 1'b0; shift_in = 1'b0;
        a = '0; b = '0; rst = 1'b0;
        test_reset();
        test_shift();
        test_mul_acc();
        test_window();
        test_len0();
        test_acc_wrap();
        test_cset_collide();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
